// File: rtl/req_ack_chk_pkg.sv
// rtl/req_ack_chk_pkg.sv - shared types for the req/ack window checker
// Contents: per-channel FSM state enum, fail cause enum, fail code width.
package req_ack_chk_pkg;

    localparam int FC_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } chan_state_e;

    typedef enum logic [FC_W-1:0] {
        FC_NONE    = 2'd0,
        FC_EARLY   = 2'd1,
        FC_TIMEOUT = 2'd2,
        FC_OVERLAP = 2'd3
    } fail_code_e;

endpackage

// File: rtl/req_ack_chk_chan.sv
// rtl/req_ack_chk_chan.sv - one channel: edge detect, window FSM, saturating stats
// Ports: clk, rst_n (sync, active low), req/ack levels, clr_stats;
//        busy (attempt pending), pass/fail one-cycle pulses, fail_code,
//        pass_cnt/fail_cnt saturating counters.
module req_ack_chk_chan
    import req_ack_chk_pkg::*;
#(
    parameter int MIN_DLY      = 2,
    parameter int MAX_DLY      = 5,
    parameter int STRICT_EARLY = 0,
    parameter int STAT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              ack,
    input  logic              clr_stats,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [FC_W-1:0]   fail_code,
    output logic [STAT_W-1:0] pass_cnt,
    output logic [STAT_W-1:0] fail_cnt
);

    localparam int DW = $clog2(MAX_DLY + 1);
    localparam logic [DW-1:0] MIN_V = DW'(MIN_DLY);
    localparam logic [DW-1:0] MAX_V = DW'(MAX_DLY);
    localparam logic [DW-1:0] ONE_V = DW'(1);

    logic              req_q, ack_q;
    chan_state_e       state_q, state_d;
    logic [DW-1:0]     dist_q, dist_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    fail_code_e        code_q, code_d;
    logic [STAT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [STAT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic              req_rise, ack_rise;

    assign req_rise = req & ~req_q;
    assign ack_rise = ack & ~ack_q;

    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        code_d  = FC_NONE;
        case (state_q)
            ST_IDLE: begin
                // an ack rise on the starting edge belongs to no attempt
                if (req_rise) begin
                    state_d = ST_WAIT;
                    dist_d  = ONE_V;
                end
            end
            ST_WAIT: begin
                if (ack_rise && dist_q >= MIN_V) begin
                    pass_d = 1'b1;
                end else if (ack_rise && STRICT_EARLY != 0) begin
                    fail_d = 1'b1;
                    code_d = FC_EARLY;
                end else if (dist_q == MAX_V) begin
                    fail_d = 1'b1;
                    code_d = FC_TIMEOUT;
                end
                if (pass_d || fail_d) begin
                    // a req rise on the deciding edge starts a fresh attempt
                    // instead of being flagged as overlap
                    state_d = req_rise ? ST_WAIT : ST_IDLE;
                    dist_d  = req_rise ? ONE_V : '0;
                end else begin
                    dist_d = dist_q + 1'b1;
                    if (req_rise) begin
                        fail_d = 1'b1;
                        code_d = FC_OVERLAP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                dist_d  = '0;
            end
        endcase

        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (clr_stats) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else begin
            if (pass_d && pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
            if (fail_d && fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // edge history tracks the live levels even in reset so a level
        // already high at release is not seen as a rise
        req_q <= req;
        ack_q <= ack;
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dist_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            code_q     <= FC_NONE;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dist_q     <= dist_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign busy      = (state_q == ST_WAIT);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: rtl/req_ack_window_chk.sv
// rtl/req_ack_window_chk.sv - multi-channel req/ack latency window checker
// Ports: clk, rst_n (sync, active low), req[NUM_CH], ack[NUM_CH], clr_stats;
//        busy/pass/fail [NUM_CH], fail_code [2*NUM_CH],
//        pass_cnt/fail_cnt [STAT_W*NUM_CH], channel i at [i*STAT_W +: STAT_W].
module req_ack_window_chk
    import req_ack_chk_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int MIN_DLY      = 2,
    parameter int MAX_DLY      = 5,
    parameter int STRICT_EARLY = 0,
    parameter int STAT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        ack,
    input  logic                     clr_stats,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        pass,
    output logic [NUM_CH-1:0]        fail,
    output logic [FC_W*NUM_CH-1:0]   fail_code,
    output logic [STAT_W*NUM_CH-1:0] pass_cnt,
    output logic [STAT_W*NUM_CH-1:0] fail_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_ack_chk_chan #(
            .MIN_DLY      (MIN_DLY),
            .MAX_DLY      (MAX_DLY),
            .STRICT_EARLY (STRICT_EARLY),
            .STAT_W       (STAT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req[i]),
            .ack       (ack[i]),
            .clr_stats (clr_stats),
            .busy      (busy[i]),
            .pass      (pass[i]),
            .fail      (fail[i]),
            .fail_code (fail_code[i*FC_W +: FC_W]),
            .pass_cnt  (pass_cnt[i*STAT_W +: STAT_W]),
            .fail_cnt  (fail_cnt[i*STAT_W +: STAT_W])
        );
    end

endmodule
